// File: rtl/glitch_pkg.sv
// Shared types and helpers for the trigger conditioning path.
// Holds the FSM state type, edge-select codes and a counter-width helper.
package glitch_pkg;

    typedef enum logic [1:0] {
        TC_DISARMED,
        TC_ARMED,
        TC_HOLDOFF
    } tc_state_t;

    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;
    localparam logic [1:0] EDGE_NONE = 2'b11;

    // Bits needed to hold the values 0..n, never less than one.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_filter.sv
// Metastability synchroniser followed by a stability (deglitch) filter.
// Ports: clk, rst (async, active-high), d_async (raw pin) -> level (filtered).
module sync_filter
    import glitch_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic level
);

    localparam int FW = cnt_width(FILTER_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FW-1:0]          cnt_q;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
        end
    end

    // The new value is accepted only after it has differed from the
    // current level for FILTER_CYCLES consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            cnt_q <= '0;
        end else if (sync == level) begin
            cnt_q <= '0;
        end else if (cnt_q == FW'(FILTER_CYCLES - 1)) begin
            level <= sync;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/trigger_conditioner.sv
// Turns the raw trigger pin into a single-cycle pulse for glitchGen.
// Ports: clk, rst, trig_in, arm, one_shot, edge_sel -> trig_pulse,
//        trig_level, armed, overrun, trig_count.
module trigger_conditioner
    import glitch_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 12,
    parameter int HOLDOFF_CYCLES = 12_000_000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig_in,
    input  logic             arm,
    input  logic             one_shot,
    input  logic [1:0]       edge_sel,
    output logic             trig_pulse,
    output logic             trig_level,
    output logic             armed,
    output logic             overrun,
    output logic [CNT_W-1:0] trig_count
);

    localparam int HW        = cnt_width(HOLDOFF_CYCLES);
    localparam int HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;

    tc_state_t        state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pulse_q, pulse_d;
    logic             over_q, over_d;
    logic             lock_q, lock_d;
    logic             arm_q;
    logic             level_d;
    logic             qual, qual_q;
    logic             rise, fall;

    sync_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filt (
        .clk    (clk),
        .rst    (rst),
        .d_async(trig_in),
        .level  (trig_level)
    );

    assign rise = trig_level & ~level_d;
    assign fall = ~trig_level & level_d;

    always_comb begin
        qual = 1'b0;
        unique case (edge_sel)
            EDGE_RISE: qual = rise;
            EDGE_FALL: qual = fall;
            EDGE_BOTH: qual = rise | fall;
            EDGE_NONE: qual = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= 1'b0;
            qual_q  <= 1'b0;
            arm_q   <= 1'b0;
            state_q <= TC_DISARMED;
            hold_q  <= '0;
            count_q <= '0;
            pulse_q <= 1'b0;
            over_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            level_d <= trig_level;
            qual_q  <= qual;
            arm_q   <= arm;
            state_q <= state_d;
            hold_q  <= hold_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
            over_q  <= over_d;
            lock_q  <= lock_d;
        end
    end

    // lock_q keeps a one-shot fire from re-arming until arm drops.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        count_d = count_q;
        pulse_d = 1'b0;
        over_d  = over_q;
        lock_d  = lock_q;
        if (arm && !arm_q) over_d = 1'b0;
        if (!arm) lock_d = 1'b0;
        case (state_q)
            TC_DISARMED: begin
                if (arm && !lock_q) state_d = TC_ARMED;
            end
            TC_ARMED: begin
                // An edge beats arm dropping in the same cycle.
                if (qual_q && !pulse_q) begin
                    pulse_d = 1'b1;
                    if (count_q != '1) count_d = count_q + 1'b1;
                    if (one_shot) begin
                        state_d = TC_DISARMED;
                        lock_d  = 1'b1;
                    end else if (HOLDOFF_CYCLES == 0) begin
                        state_d = TC_ARMED;
                    end else begin
                        state_d = TC_HOLDOFF;
                        hold_d  = HW'(HOLD_LOAD);
                    end
                end else if (!arm) begin
                    state_d = TC_DISARMED;
                end
            end
            TC_HOLDOFF: begin
                if (qual_q) over_d = 1'b1;
                if (hold_q == '0) begin
                    state_d = arm ? TC_ARMED : TC_DISARMED;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = TC_DISARMED;
        endcase
    end

    assign trig_pulse = pulse_q;
    assign armed      = (state_q == TC_ARMED);
    assign overrun    = over_q;
    assign trig_count = count_q;

endmodule

// File: tb/tb_trigger_conditioner.sv
// Self-checking bench for trigger_conditioner: table-driven scenarios,
// hand-written corner sequences and random stimulus against a model.
module tb_trigger_conditioner;

    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int HOLD = 10;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          trig_in = 1'b0;
    logic          arm = 1'b0;
    logic          one_shot = 1'b0;
    logic [1:0]    edge_sel = 2'b00;
    logic          trig_pulse;
    logic          trig_level;
    logic          armed;
    logic          overrun;
    logic [CW-1:0] trig_count;

    int n_checks = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    trigger_conditioner #(
        .SYNC_STAGES   (SYNC),
        .FILTER_CYCLES (FILT),
        .HOLDOFF_CYCLES(HOLD),
        .CNT_W         (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trig_in   (trig_in),
        .arm       (arm),
        .one_shot  (one_shot),
        .edge_sel  (edge_sel),
        .trig_pulse(trig_pulse),
        .trig_level(trig_level),
        .armed     (armed),
        .overrun   (overrun),
        .trig_count(trig_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Level: flips once the last FILT synchronised samples all disagree
    // with it. Holdoff: tracked as an absolute end cycle.
    localparam int M_DIS  = 0;
    localparam int M_ARM  = 1;
    localparam int M_HOLD = 2;

    bit hist[$];
    int m_cyc;
    bit m_level, m_level_d, m_qual, m_pulse, m_over, m_lock, m_arm_p;
    int m_mode, m_hold_end, m_count;

    task automatic model_step;
        bit nl, nq, fire, diff;
        int n, nmode;
        if (rst) begin
            m_cyc = 0;
            hist.delete();
            for (int i = 0; i < SYNC + FILT; i++) hist.push_back(1'b0);
            m_level = 0; m_level_d = 0; m_qual = 0; m_pulse = 0;
            m_over = 0; m_lock = 0; m_arm_p = 0;
            m_mode = M_DIS; m_hold_end = 0; m_count = 0;
        end else begin
            m_cyc++;
            hist.push_back(trig_in);
            if (hist.size() > 64) void'(hist.pop_front());
            n = hist.size();
            diff = 1'b1;
            for (int k = 0; k < FILT; k++)
                if (hist[n-1-SYNC-k] == m_level) diff = 1'b0;
            nl = diff ? !m_level : m_level;
            if (edge_sel == 2'd0) nq = m_level && !m_level_d;
            else if (edge_sel == 2'd1) nq = !m_level && m_level_d;
            else if (edge_sel == 2'd2) nq = (m_level != m_level_d);
            else nq = 1'b0;

            fire = (m_mode == M_ARM) && m_qual && !m_pulse;
            if (arm && !m_arm_p) m_over = 1'b0;
            if (m_mode == M_HOLD && m_qual) m_over = 1'b1;
            nmode = m_mode;
            if (m_mode == M_DIS) begin
                if (arm && !m_lock) nmode = M_ARM;
            end else if (m_mode == M_ARM) begin
                if (fire) begin
                    if (one_shot) nmode = M_DIS;
                    else begin
                        nmode = M_HOLD;
                        m_hold_end = m_cyc + HOLD;
                    end
                end else if (!arm) nmode = M_DIS;
            end else begin
                if (m_cyc == m_hold_end) nmode = arm ? M_ARM : M_DIS;
            end
            if (fire && m_count < CMAX) m_count++;
            if (fire && one_shot) m_lock = 1'b1;
            else if (!arm) m_lock = 1'b0;
            m_mode = nmode;
            m_pulse = fire;
            m_level_d = m_level;
            m_level = nl;
            m_qual = nq;
            m_arm_p = arm;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en && !rst) begin
            chk("m_pulse", int'(trig_pulse), int'(m_pulse));
            chk("m_level", int'(trig_level), int'(m_level));
            chk("m_armed", int'(armed), int'(m_mode == M_ARM));
            chk("m_overrun", int'(overrun), int'(m_over));
            chk("m_count", int'(trig_count), m_count);
        end
    end

    // ---------------- directed tests ----------------
    typedef struct {
        int       w;
        logic [1:0] esel;
        bit       os;
        int       np;
        bit       ov;
        bit       am;
    } tc_t;

    tc_t tbl[10];

    task automatic settle;
        edge_sel = 2'b11;
        trig_in = 1'b0;
        one_shot = 1'b0;
        arm = 1'b0;
        tick;
        arm = 1'b1;
        repeat (30) tick;
    endtask

    initial begin
        int np;
        int hold_left;
        tbl[0] = '{3,  2'b00, 1'b0, 0, 1'b0, 1'b1};
        tbl[1] = '{4,  2'b00, 1'b0, 1, 1'b0, 1'b1};
        tbl[2] = '{4,  2'b01, 1'b0, 1, 1'b0, 1'b1};
        tbl[3] = '{4,  2'b10, 1'b0, 1, 1'b1, 1'b1};
        tbl[4] = '{8,  2'b10, 1'b0, 1, 1'b1, 1'b1};
        tbl[5] = '{10, 2'b10, 1'b0, 1, 1'b1, 1'b1};
        tbl[6] = '{11, 2'b10, 1'b0, 2, 1'b0, 1'b1};
        tbl[7] = '{20, 2'b10, 1'b0, 2, 1'b0, 1'b1};
        tbl[8] = '{20, 2'b11, 1'b0, 0, 1'b0, 1'b1};
        tbl[9] = '{20, 2'b10, 1'b1, 1, 1'b0, 1'b0};

        // reset values
        #1 rst = 1'b1;
        #1;
        chk("rst_pulse", int'(trig_pulse), 0);
        chk("rst_level", int'(trig_level), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_count", int'(trig_count), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // latency and holdoff length
        arm = 1'b1;
        edge_sel = 2'b00;
        repeat (30) tick;
        trig_in = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick;
            chk($sformatf("lat_pulse_%0d", k), int'(trig_pulse), int'(k == 8));
            if (k == 7 || k == 8 || k == 17 || k == 18)
                chk($sformatf("lat_armed_%0d", k), int'(armed), int'(k == 7 || k == 18));
        end
        chk("lat_count", int'(trig_count), 1);

        // qual and arm falling together: the edge wins
        settle;
        edge_sel = 2'b00;
        trig_in = 1'b1;
        repeat (7) tick;
        arm = 1'b0;
        tick;
        chk("armfall_pulse", int'(trig_pulse), 1);
        chk("armfall_count", int'(trig_count), 2);
        tick;
        chk("armfall_armed", int'(armed), 0);
        arm = 1'b1;

        // table-driven pulse-width scenarios
        for (int i = 0; i < 10; i++) begin
            settle;
            edge_sel = tbl[i].esel;
            one_shot = tbl[i].os;
            np = 0;
            trig_in = 1'b1;
            repeat (tbl[i].w) begin
                tick;
                if (trig_pulse) np++;
            end
            trig_in = 1'b0;
            repeat (40) begin
                tick;
                if (trig_pulse) np++;
            end
            chk($sformatf("tbl%0d_pulses", i), np, tbl[i].np);
            chk($sformatf("tbl%0d_overrun", i), int'(overrun), int'(tbl[i].ov));
            chk($sformatf("tbl%0d_armed", i), int'(armed), int'(tbl[i].am));
            chk($sformatf("tbl%0d_level", i), int'(trig_level), 0);
            if (tbl[i].ov) begin
                arm = 1'b0;
                tick;
                arm = 1'b1;
                tick;
                chk($sformatf("tbl%0d_ovclr", i), int'(overrun), 0);
            end
        end

        // random stimulus against the model
        settle;
        hold_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_left == 0) begin
                trig_in = !trig_in;
                hold_left = $urandom_range(1, 25);
            end
            hold_left--;
            if ($urandom_range(0, 99) < 3) arm = !arm;
            if ($urandom_range(0, 99) < 1) one_shot = !one_shot;
            if ($urandom_range(0, 99) < 2) edge_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 999) < 2) begin
                rst = 1'b1;
                tick;
                rst = 1'b0;
            end
            tick;
        end

        // saturation
        rst = 1'b1;
        tick;
        rst = 1'b0;
        settle;
        edge_sel = 2'b00;
        for (int f = 1; f <= 20; f++) begin
            trig_in = 1'b1;
            repeat (8) tick;
            trig_in = 1'b0;
            repeat (8) tick;
            if (f == 10) chk("sat_count_10", int'(trig_count), 10);
        end
        chk("sat_count_20", int'(trig_count), CMAX);

        // reset in the middle of a holdoff
        trig_in = 1'b1;
        repeat (11) tick;
        chk("hold_armed", int'(armed), 0);
        rst = 1'b1;
        #1;
        chk("mid_pulse", int'(trig_pulse), 0);
        chk("mid_level", int'(trig_level), 0);
        chk("mid_armed", int'(armed), 0);
        chk("mid_overrun", int'(overrun), 0);
        chk("mid_count", int'(trig_count), 0);
        trig_in = 1'b0;
        tick;
        rst = 1'b0;
        arm = 1'b1;
        tick;
        chk("rearm_armed", int'(armed), 1);
        repeat (5) tick;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
